// File: rtl/chunked_serial_adder_if.sv
// chunked_serial_adder_if
// Request/result bundle for the chunked serial adder.
//   start, sub, a, b, cin : request side, driven by the master
//   busy, done, sum, cout, ovf : status/result side, driven by the adder
interface chunked_serial_adder_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, sub, a, b, cin,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, sub, a, b, cin,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/chunked_serial_adder.sv
// chunked_serial_adder
// Multi-cycle WIDTH-bit adder/subtractor that walks a CHUNK-bit ripple slice
// from LSB to MSB, one chunk per clock.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset (aborts any operation)
//   bus  : slave side of chunked_serial_adder_if
//          start/sub/a/b/cin sampled when start=1 and busy=0;
//          busy while chunks are processed, done pulses one cycle when
//          sum/cout/ovf are updated; results hold until the next done.
module chunked_serial_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  chunked_serial_adder_if.slave bus
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [KW-1:0]    k;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0] sum_q;
  logic             carry;
  logic             cout_q;
  logic             ovf_q;
  logic [CHUNK-1:0] a_ch;
  logic [CHUNK-1:0] b_ch;
  logic [CHUNK-1:0] s_ch;
  logic             rc;
  logic             c_msb;
  logic             busy;
  logic             done;
  logic             accept;
  logic             last;

  // A request is taken whenever no operation is running, including the
  // DONE cycle, which gives back-to-back operation.
  assign accept = bus.start && (state != RUN);
  assign last   = (k == KW'(NCH - 1));

  // CHUNK-bit ripple slice on chunk k. c_msb is the carry into the top bit
  // of the slice; on the last chunk that is the carry into bit WIDTH-1.
  always_comb begin
    a_ch  = a_q[int'(k)*CHUNK +: CHUNK];
    b_ch  = b_q[int'(k)*CHUNK +: CHUNK];
    s_ch  = '0;
    c_msb = 1'b0;
    rc    = carry;
    for (int i = 0; i < CHUNK; i++) begin
      if (i == CHUNK - 1) c_msb = rc;
      s_ch[i] = a_ch[i] ^ b_ch[i] ^ rc;
      rc      = (a_ch[i] & b_ch[i]) | (rc & (a_ch[i] ^ b_ch[i]));
    end
    acc_nxt = acc;
    acc_nxt[int'(k)*CHUNK +: CHUNK] = s_ch;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    state_nxt = bus.start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  // Control and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      k      <= '0;
      carry  <= 1'b0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (accept) begin
      // Subtract is a + ~b + 1 - cin, so both b and the carry are inverted.
      carry <= bus.cin ^ bus.sub;
      k     <= '0;
    end else if (state == RUN) begin
      carry <= rc;
      k     <= last ? '0 : k + 1'b1;
      if (last) begin
        sum_q  <= acc_nxt;
        cout_q <= rc;
        ovf_q  <= c_msb ^ rc;
      end
    end
  end

  // Operand and accumulator storage
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q <= bus.a;
      b_q <= bus.b ^ {WIDTH{bus.sub}};
    end
    if (state == RUN) acc <= acc_nxt;
  end

  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_chunked_serial_adder.sv
// tb_chunked_serial_adder
// Directed bench for chunked_serial_adder: a 16/4 instance driven through
// reset, arithmetic corner cases and handshake scenarios, compared every
// cycle against an arithmetic model, plus exhaustive 4-bit instances with
// CHUNK = 1, 2, 4.
module tb_chunked_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  bit   sweep_fin [3];

  chunked_serial_adder_if #(.WIDTH(16)) bus16 ();
  chunked_serial_adder #(.WIDTH(16), .CHUNK(4)) dut16 (
    .clk(clk),
    .rst(rst),
    .bus(bus16.slave)
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Result from plain integer arithmetic: {ovf, cout, sum}.
  function automatic logic [33:0] ref_op(input int w, input int ua, input int ub,
                                         input bit cin, input bit sub);
    int m, sa, sb, u, sg, s;
    bit co, ov;
    m  = 1 << w;
    sa = (ua >= m / 2) ? ua - m : ua;
    sb = (ub >= m / 2) ? ub - m : ub;
    if (sub) begin
      u  = ua - ub - int'(cin);
      sg = sa - sb - int'(cin);
      co = (u >= 0);
    end else begin
      u  = ua + ub + int'(cin);
      sg = sa + sb + int'(cin);
      co = (u >= m);
    end
    s  = (u + m) % m;
    ov = (sg >= m / 2) || (sg < -(m / 2));
    return {ov, co, s};
  endfunction

  // Cycle model for the 16-bit instance: m_cnt counts edges left until done.
  int          m_cnt = 0;
  logic        m_done = 1'b0;
  logic [33:0] p_res = '0;
  logic [33:0] m_res = '0;
  bit          model_en = 1'b0;

  always @(posedge clk) begin
    model_en <= 1'b1;
    if (rst) begin
      m_cnt  <= 0;
      m_done <= 1'b0;
      m_res  <= '0;
    end else if (m_cnt == 0 && bus16.start) begin
      p_res  <= ref_op(16, int'(bus16.a), int'(bus16.b), bus16.cin, bus16.sub);
      m_cnt  <= 4;
      m_done <= 1'b0;
    end else if (m_cnt > 0) begin
      m_cnt  <= m_cnt - 1;
      m_done <= (m_cnt == 1);
      if (m_cnt == 1) m_res <= p_res;
    end else begin
      m_done <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (model_en) begin
      check("cmp_busy", bus16.busy, 32'(m_cnt != 0));
      check("cmp_done", bus16.done, 32'(m_done));
      check("cmp_sum",  bus16.sum,  m_res[15:0]);
      check("cmp_cout", bus16.cout, m_res[32]);
      check("cmp_ovf",  bus16.ovf,  m_res[33]);
    end
  end

  task automatic do_op(input string nm, input logic [15:0] a, input logic [15:0] b,
                       input logic cin, input logic sub,
                       input logic [15:0] es, input logic ec, input logic eo);
    int lat;
    @(negedge clk);
    bus16.a = a; bus16.b = b; bus16.cin = cin; bus16.sub = sub; bus16.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus16.start = 1'b0;
    lat = 0;
    while (!bus16.done && lat < 20) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check({nm, "_latency"}, lat, 4);
    check({nm, "_sum"}, bus16.sum, es);
    check({nm, "_cout"}, bus16.cout, ec);
    check({nm, "_ovf"}, bus16.ovf, eo);
    @(negedge clk);
    check({nm, "_done_width"}, bus16.done, 0);
  endtask

  task automatic wait_done(input string nm, output int t);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus16.done && n < 40);
    check({nm, "_done_seen"}, bus16.done, 1);
    t = cyc;
  endtask

  initial begin
    int t1, t2, n;
    rst = 1'b1;
    bus16.start = 1'b1; bus16.a = 16'hABCD; bus16.b = 16'h1234;
    bus16.cin = 1'b1; bus16.sub = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", bus16.busy, 0);
    check("rst_done", bus16.done, 0);
    check("rst_sum",  bus16.sum,  0);
    check("rst_cout", bus16.cout, 0);
    check("rst_ovf",  bus16.ovf,  0);
    rst = 1'b0;
    bus16.start = 1'b0;
    @(negedge clk);
    check("rst_no_op_busy", bus16.busy, 0);

    do_op("wrap",    16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    do_op("sovf",    16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    do_op("sub_neg", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    do_op("sub_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    do_op("cin_add", 16'h00FF, 16'h0F00, 1'b1, 1'b0, 16'h1000, 1'b0, 1'b0);

    // Operands changed and start pulsed while busy: result uses captured values.
    @(negedge clk);
    bus16.a = 16'h1234; bus16.b = 16'h1111; bus16.cin = 1'b0; bus16.sub = 1'b0;
    bus16.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus16.start = 1'b0;
    bus16.a = 16'hFFFF; bus16.b = 16'hFFFF; bus16.cin = 1'b1; bus16.sub = 1'b1;
    @(negedge clk);
    bus16.start = 1'b1;
    @(negedge clk);
    bus16.start = 1'b0;
    wait_done("robust", t1);
    check("robust_sum",  bus16.sum,  16'h2345);
    check("robust_cout", bus16.cout, 0);
    check("robust_ovf",  bus16.ovf,  0);

    // start held through the done cycle: second op accepted on that edge.
    @(negedge clk);
    bus16.a = 16'h0001; bus16.b = 16'h0002; bus16.cin = 1'b0; bus16.sub = 1'b0;
    bus16.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus16.a = 16'h0010; bus16.b = 16'h0020;
    wait_done("b2b_first", t1);
    check("b2b_sum1", bus16.sum, 16'h0003);
    wait_done("b2b_second", t2);
    bus16.start = 1'b0;
    check("b2b_spacing", t2 - t1, 5);
    check("b2b_sum2", bus16.sum, 16'h0030);
    @(negedge clk);
    check("b2b_done_width", bus16.done, 0);

    // Reset after E2 aborts the operation and clears the results.
    @(negedge clk);
    bus16.a = 16'hFFFF; bus16.b = 16'h0001; bus16.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus16.start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", bus16.busy, 0);
    check("abort_done", bus16.done, 0);
    check("abort_sum",  bus16.sum,  0);
    check("abort_cout", bus16.cout, 0);
    check("abort_ovf",  bus16.ovf,  0);
    repeat (6) begin
      @(negedge clk);
      check("abort_no_done", bus16.done, 0);
    end

    n = 0;
    while (!(sweep_fin[0] && sweep_fin[1] && sweep_fin[2]) && n < 30000) begin
      @(negedge clk);
      n++;
    end
    check("sweep_complete", 32'(sweep_fin[0] && sweep_fin[1] && sweep_fin[2]), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Exhaustive 4-bit instances with CHUNK = 1, 2, 4.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_sweep
      localparam int C = 1 << gi;
      localparam int N = 4 / C;
      logic rst_sw;
      chunked_serial_adder_if #(.WIDTH(4)) sif ();
      chunked_serial_adder #(.WIDTH(4), .CHUNK(C)) dut (
        .clk(clk),
        .rst(rst_sw),
        .bus(sif.slave)
      );

      initial begin
        int lat;
        logic [33:0] r;
        rst_sw = 1'b1;
        sif.start = 1'b0; sif.a = '0; sif.b = '0; sif.cin = 1'b0; sif.sub = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_sw = 1'b0;
        for (int s = 0; s < 2; s++) begin
          for (int ci = 0; ci < 2; ci++) begin
            for (int ai = 0; ai < 16; ai++) begin
              for (int bi = 0; bi < 16; bi++) begin
                sif.a = 4'(ai); sif.b = 4'(bi); sif.cin = ci[0]; sif.sub = s[0];
                sif.start = 1'b1;
                @(posedge clk);
                @(negedge clk);
                sif.start = 1'b0;
                lat = 0;
                while (!sif.done && lat < 12) begin
                  @(posedge clk);
                  lat++;
                  @(negedge clk);
                end
                r = ref_op(4, ai, bi, ci[0], s[0]);
                check($sformatf("sweep_c%0d_lat a=%0d b=%0d cin=%0d sub=%0d", C, ai, bi, ci, s),
                      lat, N);
                check($sformatf("sweep_c%0d_sum a=%0d b=%0d cin=%0d sub=%0d", C, ai, bi, ci, s),
                      {sif.cout, sif.sum}, {r[32], r[3:0]});
                check($sformatf("sweep_c%0d_ovf a=%0d b=%0d cin=%0d sub=%0d", C, ai, bi, ci, s),
                      sif.ovf, r[33]);
              end
            end
          end
        end
        sweep_fin[gi] = 1'b1;
      end
    end
  endgenerate

endmodule
